// File: rtl/joy_serial_mp.sv
// ---------------------------------------------------------------------------------------------
// joy_serial_mp -- parametrised serial joystick reader for the UserIO port.
//
// Drives a daisy-chain of 74HC165-style shift registers (one per player) and deserialises
// PLAYERS*BITS button bits per frame. Buttons on the wire are active-low; the committed word
// is active-high and only ever changes as a whole frame, together with a one-clk frame_done.
//
// Frame sequence: GAP (idle ticks) -> LOAD (parallel load, one tick) -> SHIFT (two ticks per
// bit, one tick for the last bit) -> COMMIT (one clk). All timing is in units of a shift tick
// of DIV clk cycles. Frame period with enable held high is DIV*(2*N+GAP)+1 clks.
//
// Parameters:
//   PLAYERS  number of chained adapters/players (1..4)
//   BITS     bits per player (1..16)
//   DIV      clk cycles per shift tick (>= 2)
//   GAP      idle ticks between frames (>= 1)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   allows a new frame to start (checked only when the gap expires)
//   joy_data    in   serial data from the chain, pressed button reads 0
//   joy_load    out  active-low parallel load to the chain
//   joy_clk     out  shift clock to the chain, idles low
//   joystick    out  committed buttons, active-high, player p bit b at index p*BITS+b
//   frame_done  out  one-clk pulse each time a frame commits
//
// Optional feature (compile-time macro JOY_SERIAL_DEBOUNCE_EN):
//   When defined, a frame is committed only if it matches the previous frame, so a change
//   shows up after two identical consecutive frames. frame_done still pulses every frame.
// ---------------------------------------------------------------------------------------------

module joy_serial_mp #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned BITS    = 12,
    parameter int unsigned DIV     = 24,
    parameter int unsigned GAP     = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_load,
    output logic                      joy_clk,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      frame_done
);

    localparam int unsigned N    = PLAYERS * BITS;
    localparam int unsigned CntW = $clog2(DIV);
    localparam int unsigned BitW = $clog2(N) + 1;
    localparam int unsigned GapW = $clog2(GAP + 1);

    localparam logic [CntW-1:0] TickLast = CntW'(DIV - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(N - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP - 1);

    typedef enum logic [1:0] {
        StGap,
        StLoad,
        StShift,
        StCommit
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] div_cnt_q;   // clk cycles within the current tick
    logic [GapW-1:0] gap_cnt_q;   // ticks spent in GAP, saturates at GAP-1
    logic [BitW-1:0] bit_idx_q;   // index of the bit being shifted in
    logic            phase_b_q;   // 0: waiting to sample, 1: joy_clk high
    logic [N-1:0]    shadow_q;    // raw (active-low) bits of the frame in progress
`ifdef JOY_SERIAL_DEBOUNCE_EN
    logic [N-1:0]    prev_shadow_q;
`endif

    logic tick;
    assign tick = (div_cnt_q == TickLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StGap;
            div_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            bit_idx_q     <= '0;
            phase_b_q     <= 1'b0;
            shadow_q      <= '1;
`ifdef JOY_SERIAL_DEBOUNCE_EN
            prev_shadow_q <= '1;
`endif
            joy_load      <= 1'b1;
            joy_clk       <= 1'b0;
            joystick      <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Free-running tick divider. Every state change except COMMIT->GAP happens on a
            // tick, where the counter wraps to 0 anyway, so only that exit clears it.
            div_cnt_q  <= tick ? '0 : div_cnt_q + CntW'(1);

            unique case (state_q)
                StGap: begin
                    if (tick) begin
                        if (gap_cnt_q == GapLast) begin
                            // Gap expired: start a frame if allowed, else hold and re-check
                            // on every following tick.
                            if (enable) begin
                                state_q   <= StLoad;
                                joy_load  <= 1'b0;
                                gap_cnt_q <= '0;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GapW'(1);
                        end
                    end
                end

                StLoad: begin
                    if (tick) begin
                        state_q   <= StShift;
                        joy_load  <= 1'b1;
                        bit_idx_q <= '0;
                        phase_b_q <= 1'b0;
                    end
                end

                StShift: begin
                    if (tick) begin
                        if (!phase_b_q) begin
                            for (int k = 0; k < int'(N); k++) begin
                                if (bit_idx_q == BitW'(k)) begin
                                    shadow_q[k] <= joy_data;
                                end
                            end
                            if (bit_idx_q == BitLast) begin
                                // No clock after the last bit; the chain is reloaded next
                                // frame anyway.
                                state_q <= StCommit;
                            end else begin
                                joy_clk   <= 1'b1;
                                phase_b_q <= 1'b1;
                            end
                        end else begin
                            joy_clk   <= 1'b0;
                            phase_b_q <= 1'b0;
                            bit_idx_q <= bit_idx_q + BitW'(1);
                        end
                    end
                end

                StCommit: begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
                    if (shadow_q == prev_shadow_q) begin
                        joystick <= ~shadow_q;
                    end
                    prev_shadow_q <= shadow_q;
`else
                    joystick <= ~shadow_q;
`endif
                    frame_done <= 1'b1;
                    state_q    <= StGap;
                    gap_cnt_q  <= '0;
                    div_cnt_q  <= '0;
                end

                default: begin
                    state_q <= StGap;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_serial_mp.sv
// ---------------------------------------------------------------------------------------------
// tb_joy_serial_mp -- directed self-checking bench for joy_serial_mp.
//
// DUT configured as PLAYERS=2, BITS=12, DIV=4, GAP=8 (N=24). A behavioural 24-bit 74HC165
// chain model feeds joy_data from the active-low word raw. Expected frame period is
// 4*(48+8)+1 = 225 clks; first load comes 8 ticks = 32 clks after reset release.
// ---------------------------------------------------------------------------------------------

module tb_joy_serial_mp;

`ifdef JOY_SERIAL_DEBOUNCE_EN
    localparam bit Deb = 1'b1;
`else
    localparam bit Deb = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        joy_data;
    logic        joy_load;
    logic        joy_clk;
    logic [23:0] joystick;
    logic        frame_done;

    joy_serial_mp #(
        .PLAYERS (2),
        .BITS    (12),
        .DIV     (4),
        .GAP     (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .joy_data   (joy_data),
        .joy_load   (joy_load),
        .joy_clk    (joy_clk),
        .joystick   (joystick),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74HC165 chain model: parallel load while joy_load is low, shift toward bit 0 on each
    // joy_clk rise. raw is active-low (0 = pressed); raw[0] comes out first.
    logic [23:0] raw;
    logic [23:0] sr;
    logic        jclk_prev;
    always @(posedge clk) begin
        jclk_prev <= joy_clk;
        if (!joy_load) sr <= raw;
        else if (joy_clk && !jclk_prev) sr <= {1'b1, sr[23:1]};
    end
    assign joy_data = sr[0];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until frame_done is seen (bounded).
    task automatic wait_frame(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 3000);
        check(tag, {31'd0, frame_done}, 32'd1);
    endtask

    // Counts negedges until joy_load is seen low (bounded).
    task automatic wait_load_low(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (joy_load && n < 3000);
        check(tag, {31'd0, joy_load}, 32'd0);
    endtask

    // Waits for the end of the LOAD pulse (bounded).
    task automatic wait_load_rise(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!joy_load && n < 100);
        check(tag, {31'd0, joy_load}, 32'd1);
    endtask

    int   n;
    int   w;
    int   rises;
    int   loads;
    int   dones;
    logic prev;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        raw     = 24'hFFFFFF;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_joy_load",   {31'd0, joy_load},   32'd1);
        check("rst_joy_clk",    {31'd0, joy_clk},    32'd0);
        check("rst_joystick",   {8'd0, joystick},    32'h000000);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // First load 32 clks after release, low for exactly 4 clks.
        reset_n = 1'b1;
        wait_load_low("first_load_seen", n);
        check("first_load_delay", n, 32);
        w = 1;
        do begin
            @(negedge clk);
            if (!joy_load) w++;
        end while (!joy_load && w < 100);
        check("load_low_width", w, 4);

        // 23 joy_clk rises in a frame; nothing pressed commits zero.
        rises = 0;
        prev  = joy_clk;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (joy_clk && !prev) rises++;
            prev = joy_clk;
        end while (!frame_done && n < 3000);
        check("frame1_seen", {31'd0, frame_done}, 32'd1);
        check("clk_rises", rises, 23);
        check("idle_joystick", {8'd0, joystick}, 32'h000000);

        // Player 0 bit 0 pressed.
        raw = ~24'h000001;
        wait_frame("p0b0_f1_seen", n);
        check("frame_period", n, 225);
        check("p0b0_f1", {8'd0, joystick}, Deb ? 32'h000000 : 32'h000001);
        @(negedge clk);
        check("done_pulse_width", {31'd0, frame_done}, 32'd0);
        wait_frame("p0b0_f2_seen", n);
        check("p0b0_f2", {8'd0, joystick}, 32'h000001);

        // Player 1 bit 11 pressed.
        raw = ~24'h800000;
        wait_frame("p1b11_f1_seen", n);
        check("p1b11_f1", {8'd0, joystick}, Deb ? 32'h000001 : 32'h800000);
        wait_frame("p1b11_f2_seen", n);
        check("p1b11_f2", {8'd0, joystick}, 32'h800000);

        // Drop enable mid-SHIFT: the frame finishes, then the block idles.
        wait_load_low("en_load_seen", n);
        wait_load_rise("en_load_rise");
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_frame("en_last_frame", n);
        loads = 0;
        dones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!joy_load) loads++;
            if (frame_done) dones++;
        end
        check("disabled_loads", loads, 0);
        check("disabled_dones", dones, 0);
        enable = 1'b1;
        wait_load_low("reenable_load_seen", n);
        check("reenable_within_32", {31'd0, n <= 32}, 32'd1);
        wait_frame("reenable_frame", n);
        check("reenable_joystick", {8'd0, joystick}, 32'h800000);

        // Reset pulse during bit 10.
        wait_load_low("rb_load_seen", n);
        wait_load_rise("rb_load_rise");
        rises = 0;
        prev  = joy_clk;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (joy_clk && !prev) rises++;
            prev = joy_clk;
        end while (rises < 10 && n < 3000);
        check("rb_rises", rises, 10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rb_joy_load",   {31'd0, joy_load},   32'd1);
        check("rb_joy_clk",    {31'd0, joy_clk},    32'd0);
        check("rb_joystick",   {8'd0, joystick},    32'h000000);
        check("rb_frame_done", {31'd0, frame_done}, 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) dones++;
        end
        check("rb_no_done", dones, 0);
        check("rb_held_joystick", {8'd0, joystick}, 32'h000000);
        reset_n = 1'b1;
        wait_load_low("rb_resume_seen", n);
        check("rb_resume_delay", n, 32);
        wait_frame("rb_f1_seen", n);
        check("rb_f1", {8'd0, joystick}, Deb ? 32'h000000 : 32'h800000);
        wait_frame("rb_f2_seen", n);
        check("rb_f2", {8'd0, joystick}, 32'h800000);

        // Single-frame glitch 24'h000003 between idle frames.
        raw = 24'hFFFFFF;
        wait_frame("gl_idle1_seen", n);
        wait_frame("gl_idle2_seen", n);
        check("gl_baseline", {8'd0, joystick}, 32'h000000);
        raw = ~24'h000003;
        wait_frame("gl_pulse_seen", n);
        raw = 24'hFFFFFF;
        check("gl_pulse", {8'd0, joystick}, Deb ? 32'h000000 : 32'h000003);
        wait_frame("gl_after_seen", n);
        check("gl_after", {8'd0, joystick}, 32'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
